// File: rtl/player_motion_ctrl.sv
// Horizontal player motion: fixed-point position/velocity with accel/decel, screen clamping,
// shot freeze and optional hit-stun respawn (enabled by defining PLAYER_HIT_STUN_EN).
`timescale 1ns/1ps
module player_motion_ctrl #(
  parameter int INITIAL_X    = 280,
  parameter int INITIAL_Y    = 420,
  parameter int FRAC_BITS    = 6,
  parameter int MAX_SPEED    = 192,
  parameter int ACCEL        = 32,
  parameter int PLAYER_WIDTH = 26,
  parameter int LEFT_BOUND   = 5,
  parameter int RIGHT_BOUND  = 635,
  parameter int STUN_FRAMES  = 60
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        startOfFrame,
  input  logic        rightArrow,
  input  logic        leftArrow,
  input  logic        shootActive,
  input  logic        playerHit,
  output logic [10:0] topLeftX,
  output logic [10:0] topLeftY,
  output logic        facingLeft,
  output logic        moving,
  output logic        stunned
);

  localparam int PW = 11 + FRAC_BITS;
  localparam int VW = $clog2(MAX_SPEED + 1) + 1;
  localparam int SW = PW + 2;

  localparam logic [PW-1:0] SPAWN_POS = PW'(INITIAL_X << FRAC_BITS);
  localparam logic [PW-1:0] LEFT_POS  = PW'(LEFT_BOUND << FRAC_BITS);
  localparam logic [PW-1:0] RIGHT_POS = PW'((RIGHT_BOUND - PLAYER_WIDTH) << FRAC_BITS);

  localparam logic signed [VW:0] VMAX_W = (VW + 1)'(MAX_SPEED);
  localparam logic signed [VW:0] ACC_W  = (VW + 1)'(ACCEL);

  typedef enum logic [1:0] {IDLE, MOVE, FROZEN, STUNNED} stateT;

  stateT                 stateReg, stateNext;
  logic [PW-1:0]         posReg, posNext;
  logic signed [VW-1:0]  velReg, velNext;
  logic                  facingReg, facingNext;

  logic signed [VW:0]    targetW, velW, velUpW, velDnW, stepW;
  logic signed [VW-1:0]  velStep;
  logic signed [SW-1:0]  sumPos;

  // Velocity one ACCEL step toward the arrow target, saturating at the target.
  always_comb begin
    targetW = '0;
    if (rightArrow && !leftArrow)
      targetW = VMAX_W;
    else if (leftArrow && !rightArrow)
      targetW = -VMAX_W;
    velW   = (VW + 1)'(velReg);
    velUpW = velW + ACC_W;
    velDnW = velW - ACC_W;
    if (velW < targetW)
      stepW = (velUpW > targetW) ? targetW : velUpW;
    else
      stepW = (velDnW < targetW) ? targetW : velDnW;
    velStep = $signed(stepW[VW-1:0]);
    sumPos  = $signed({2'b00, posReg}) + SW'(velStep);
  end

`ifdef PLAYER_HIT_STUN_EN
  localparam int CW = (STUN_FRAMES > 1) ? $clog2(STUN_FRAMES) : 1;
  localparam logic [CW-1:0] STUN_LAST = CW'(STUN_FRAMES - 1);

  logic [CW-1:0] stunCntReg, stunCntNext;
  logic          hitPendingReg, hitPendingNext;
  logic          hitNow;
`else
  logic unusedHit;
  assign unusedHit = playerHit;
`endif

  always_comb begin
    stateNext  = stateReg;
    posNext    = posReg;
    velNext    = velReg;
    facingNext = facingReg;
`ifdef PLAYER_HIT_STUN_EN
    stunCntNext    = stunCntReg;
    hitPendingNext = hitPendingReg | playerHit;
    // A hit on the same edge as the tick is honoured immediately.
    hitNow         = hitPendingNext;
`endif
    if (startOfFrame) begin
`ifdef PLAYER_HIT_STUN_EN
      if (hitNow) begin
        stateNext      = STUNNED;
        velNext        = '0;
        stunCntNext    = STUN_LAST;
        hitPendingNext = 1'b0;
      end else if (stateReg == STUNNED) begin
        if (stunCntReg != '0) begin
          stunCntNext = stunCntReg - 1'b1;
        end else begin
          posNext   = SPAWN_POS;
          stateNext = IDLE;
        end
      end else
`endif
      if (shootActive) begin
        stateNext = FROZEN;
        velNext   = '0;
      end else begin
        if (velStep != '0)
          facingNext = (velStep < 0);
        if (sumPos < $signed({2'b00, LEFT_POS})) begin
          posNext = LEFT_POS;
          velNext = '0;
        end else if (sumPos > $signed({2'b00, RIGHT_POS})) begin
          posNext = RIGHT_POS;
          velNext = '0;
        end else begin
          posNext = sumPos[PW-1:0];
          velNext = velStep;
        end
        stateNext = (velNext != '0) ? MOVE : IDLE;
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      stateReg  <= IDLE;
      posReg    <= SPAWN_POS;
      velReg    <= '0;
      facingReg <= 1'b0;
    end else begin
      stateReg  <= stateNext;
      posReg    <= posNext;
      velReg    <= velNext;
      facingReg <= facingNext;
    end
  end

`ifdef PLAYER_HIT_STUN_EN
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      stunCntReg    <= '0;
      hitPendingReg <= 1'b0;
    end else begin
      stunCntReg    <= stunCntNext;
      hitPendingReg <= hitPendingNext;
    end
  end

  assign stunned = (stateReg == STUNNED);
`else
  assign stunned = 1'b0;
`endif

  assign topLeftX   = posReg[PW-1:FRAC_BITS];
  assign topLeftY   = 11'(INITIAL_Y);
  assign facingLeft = facingReg;
  assign moving     = (velReg != '0);

endmodule

// File: tb/tb_player_motion_ctrl.sv
// Scoreboard bench for player_motion_ctrl: random and directed frames against an arithmetic model.
`timescale 1ns/1ps
module tb_player_motion_ctrl;

`ifdef PLAYER_HIT_STUN_EN
  localparam bit STUN_EN = 1'b1;
`else
  localparam bit STUN_EN = 1'b0;
`endif

  localparam int F        = 6;
  localparam int SPAWN    = 280 << F;
  localparam int LEFT_P   = 5 << F;
  localparam int RIGHT_P  = (635 - 26) << F;
  localparam int VMAX     = 192;
  localparam int ACC      = 32;

  logic        clk = 1'b0;
  logic        resetN = 1'b0;
  logic        startOfFrame = 1'b0;
  logic        rightArrow = 1'b0;
  logic        leftArrow = 1'b0;
  logic        shootActive = 1'b0;
  logic        playerHit = 1'b0;
  logic [10:0] topLeftX;
  logic [10:0] topLeftY;
  logic        facingLeft;
  logic        moving;
  logic        stunned;

  player_motion_ctrl dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .rightArrow(rightArrow), .leftArrow(leftArrow),
    .shootActive(shootActive), .playerHit(playerHit),
    .topLeftX(topLeftX), .topLeftY(topLeftY), .facingLeft(facingLeft),
    .moving(moving), .stunned(stunned)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] x;
    logic [10:0] y;
    logic        facing;
    logic        moving;
    logic        stunned;
  } obsT;

  obsT expQ[$];
  int  checks = 0;
  int  errors = 0;
  int  tickNo = 0;

  // Reference model: plain integer arithmetic over the motion rules.
  int mPos, mVel, mCnt;
  bit mFacing, mStun, mPend;

  function automatic obsT modelObs();
    obsT o;
    o.x       = 11'(mPos >>> F);
    o.y       = 11'd420;
    o.facing  = mFacing;
    o.moving  = (mVel != 0);
    o.stunned = mStun;
    return o;
  endfunction

  task automatic modelReset();
    mPos = SPAWN; mVel = 0; mCnt = 0; mFacing = 0; mStun = 0; mPend = 0;
  endtask

  task automatic modelStep(input bit sof, input bit r, input bit l, input bit s, input bit h);
    bit hit;
    int tgt, v, p;
    hit = STUN_EN && (mPend || h);
    if (!sof) begin
      mPend = hit;
      return;
    end
    if (hit) begin
      mStun = 1; mVel = 0; mCnt = 59; mPend = 0;
    end else if (mStun) begin
      if (mCnt != 0) mCnt--;
      else begin mPos = SPAWN; mStun = 0; end
    end else if (s) begin
      mVel = 0;
    end else begin
      tgt = (r && !l) ? VMAX : ((l && !r) ? -VMAX : 0);
      if (mVel < tgt) v = (mVel + ACC > tgt) ? tgt : mVel + ACC;
      else            v = (mVel - ACC < tgt) ? tgt : mVel - ACC;
      if (v != 0) mFacing = (v < 0);
      p = mPos + v;
      if (p < LEFT_P)       begin mPos = LEFT_P;  mVel = 0; end
      else if (p > RIGHT_P) begin mPos = RIGHT_P; mVel = 0; end
      else                  begin mPos = p;       mVel = v; end
    end
    expQ.push_back(modelObs());
  endtask

  // One clock cycle of stimulus, driven away from the active edge.
  task automatic cycle(input bit sof, input bit r, input bit l, input bit s, input bit h);
    @(posedge clk);
    #2;
    startOfFrame = sof; rightArrow = r; leftArrow = l; shootActive = s; playerHit = h;
    modelStep(sof, r, l, s, h);
  endtask

  task automatic tick(input bit r, input bit l, input bit s, input bit h);
    cycle(1'b1, r, l, s, h);
    cycle(1'b0, r, l, s, 1'b0);
  endtask

  task automatic expectX(input string name, input int want);
    @(posedge clk);
    #3;
    checks++;
    if (int'(topLeftX) != want) begin
      errors++;
      $display("FAIL %s: topLeftX got %0d want %0d", name, topLeftX, want);
    end else
      $display("%s: topLeftX=%0d ok", name, topLeftX);
  endtask

  task automatic checkResetOutputs(input string name);
    obsT got, want;
    got  = '{x: topLeftX, y: topLeftY, facing: facingLeft, moving: moving, stunned: stunned};
    want = '{x: 11'd280, y: 11'd420, facing: 1'b0, moving: 1'b0, stunned: 1'b0};
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got x=%0d y=%0d fac=%0d mov=%0d stun=%0d want x=280 y=420 fac=0 mov=0 stun=0",
               name, got.x, got.y, got.facing, got.moving, got.stunned);
    end else
      $display("%s: x=%0d y=%0d idle ok", name, got.x, got.y);
  endtask

  task automatic doReset(input string name);
    @(posedge clk);
    #2;
    startOfFrame = 0; rightArrow = 0; leftArrow = 0; shootActive = 0; playerHit = 0;
    resetN = 1'b0;
    #1;
    checkResetOutputs(name);
    modelReset();
    #4;
    resetN = 1'b1;
  endtask

  // Monitor: a frame tick sampled at a rising edge produces one observable update.
  initial begin
    bit   tk;
    obsT  got, want;
    forever begin
      @(posedge clk);
      tk = startOfFrame && resetN;
      #1;
      if (tk) begin
        tickNo++;
        got = '{x: topLeftX, y: topLeftY, facing: facingLeft, moving: moving, stunned: stunned};
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("FAIL tick%0d: output with no expectation (x=%0d)", tickNo, got.x);
        end else begin
          want = expQ.pop_front();
          if (got != want) begin
            errors++;
            $display("FAIL tick%0d: got x=%0d y=%0d fac=%0d mov=%0d stun=%0d want x=%0d y=%0d fac=%0d mov=%0d stun=%0d",
                     tickNo, got.x, got.y, got.facing, got.moving, got.stunned,
                     want.x, want.y, want.facing, want.moving, want.stunned);
          end else
            $display("tick%0d: x=%0d fac=%0d mov=%0d stun=%0d ok",
                     tickNo, got.x, got.facing, got.moving, got.stunned);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit r, l, s, h;
    modelReset();
    #25;
    resetN = 1'b1;
    #1;
    checkResetOutputs("reset");

    for (int i = 0; i < 6; i++) tick(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) tick(0, 0, 0, 0);

    for (int i = 0; i < 130; i++) tick(1, 0, 0, 0);
    expectX("right_bound", 609);
    tick(1, 0, 0, 0);
    expectX("right_bound_hold", 609);
    for (int i = 0; i < 250; i++) tick(0, 1, 0, 0);
    expectX("left_bound", 5);

    for (int i = 0; i < 10; i++) tick(1, 0, 0, 0);
    for (int i = 0; i < 4; i++)  tick(1, 0, 1, 0);
    for (int i = 0; i < 3; i++)  tick(1, 0, 0, 0);

    cycle(0, 1, 0, 0, 1);
    cycle(0, 1, 0, 0, 0);
    for (int i = 0; i < 64; i++) tick(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0);

    tick(0, 0, 1, 1);
    for (int i = 0; i < 63; i++) tick(0, 1, 1'(i < 5), 0);

    for (int i = 0; i < 500; i++) begin
      r = 1'($urandom_range(0, 3) != 0);
      l = 1'($urandom_range(0, 2) == 0);
      s = 1'($urandom_range(0, 9) == 0);
      h = 1'($urandom_range(0, 59) == 0);
      cycle(1, r, l, s, h);
      for (int k = 0; k < int'($urandom_range(0, 3)); k++)
        cycle(0, r, l, s, 1'($urandom_range(0, 79) == 0));
    end

    cycle(0, 1, 0, 0, 1);
    for (int i = 0; i < 5; i++) tick(1, 0, 0, 0);
    doReset("reset_mid_stun");
    for (int i = 0; i < 4; i++) tick(0, 1, 0, 0);

    @(posedge clk);
    #3;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, want 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
